// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo-style issue/execute blocks:
// opcodes, tag width and the reservation-station entry state encoding.
package tomasulo_pkg;

    localparam int TAG_W = 6;
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;

    typedef enum logic [2:0] {
        RS_FREE  = 3'd0,
        RS_WAIT  = 3'd1,
        RS_READY = 3'd2,
        RS_EXEC  = 3'd3,
        RS_DONE  = 3'd4
    } rs_state_t;

    function automatic logic is_adder_op(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/adder_pipe.sv
// Fixed-latency add/subtract unit: the result and a done pulse emerge
// LATENCY cycles after start, tracked by a shift-register valid chain.
module adder_pipe
    import tomasulo_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  sum;

    // Arithmetic wraps modulo 2^DATA_W; no overflow is reported.
    always_comb begin
        sum = (op == OP_SUB) ? (a - b) : (a + b);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= start;
            data_q[0]  <= sum;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign done   = valid_q[LATENCY-1];
    assign result = data_q[LATENCY-1];

endmodule

// File: rtl/adder_reservation_stations.sv
// Adder reservation-station bank: holds issued ADD/SUB instructions until their
// operands resolve, dispatches one at a time to adder_pipe and requests the CDB.
module adder_reservation_stations
    import tomasulo_pkg::*;
#(
    parameter int NUM_RS      = 3,
    parameter int BASE_TAG    = 1,
    parameter int DATA_W      = 32,
    parameter int ADD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue,
    input  logic [5:0]        operation,
    input  logic [4:0]        Dest_address,
    input  logic [TAG_W-1:0]  A_tag,
    input  logic [TAG_W-1:0]  B_tag,
    input  logic [DATA_W-1:0] A_value,
    input  logic [DATA_W-1:0] B_value,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_grant,
    output logic              adder_available,
    output logic [TAG_W-1:0]  adder_RS_available,
    output logic [TAG_W-1:0]  RS_issued,
    output logic              issue_error,
    output logic [TAG_W-1:0]  RS_executing_adder,
    output logic              adder_rts,
    output logic [TAG_W-1:0]  RS_finished,
    output logic [DATA_W-1:0] result_value,
    output logic [4:0]        result_dest
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } operand_t;

    typedef struct packed {
        rs_state_t  state;
        logic [5:0] op;
        logic [4:0] dest;
        operand_t   a;
        operand_t   b;
    } entry_t;

    function automatic logic [TAG_W-1:0] entry_tag(input int idx);
        return TAG_W'(BASE_TAG + idx);
    endfunction

    // A pending operand resolves when the CDB broadcasts its producer tag.
    function automatic operand_t snoop(input operand_t cur, input logic valid,
                                       input logic [TAG_W-1:0] tag,
                                       input logic [DATA_W-1:0] value);
        operand_t res;
        res = cur;
        if (valid && (cur.tag != TAG_NONE) && (cur.tag == tag)) begin
            res.tag   = TAG_NONE;
            res.value = value;
        end
        return res;
    endfunction

    entry_t rs_q [NUM_RS];
    entry_t rs_d [NUM_RS];

    logic [NUM_RS-1:0] free_vec;
    logic [NUM_RS-1:0] alloc_sel;
    logic [NUM_RS-1:0] dispatch_sel;
    logic [TAG_W-1:0]  alloc_tag;
    logic [TAG_W-1:0]  exec_tag;
    logic [4:0]        done_dest;
    logic              adder_busy;
    logic              done_any;
    logic              issue_ok;
    logic              dispatch_valid;
    logic [5:0]        disp_op;
    logic [DATA_W-1:0] disp_a;
    logic [DATA_W-1:0] disp_b;
    logic              pipe_done;
    logic [DATA_W-1:0] pipe_result;
    operand_t          issue_a;
    operand_t          issue_b;

    adder_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (ADD_LATENCY)
    ) u_adder_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (dispatch_valid),
        .op      (disp_op),
        .a       (disp_a),
        .b       (disp_b),
        .done    (pipe_done),
        .result  (pipe_result)
    );

    // State register: entries plus the one-cycle handshake pulses and result latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_RS; i++) begin
                rs_q[i] <= '0;
            end
            RS_issued    <= TAG_NONE;
            issue_error  <= 1'b0;
            RS_finished  <= TAG_NONE;
            result_value <= '0;
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                rs_q[i] <= rs_d[i];
            end
            RS_issued   <= issue_ok ? alloc_tag : TAG_NONE;
            issue_error <= issue && !issue_ok;
            RS_finished <= (done_any && cdb_grant) ? exec_tag : TAG_NONE;
            if (pipe_done) begin
                result_value <= pipe_result;
            end else if (done_any && cdb_grant) begin
                result_value <= '0;
            end
        end
    end

    // Decode from registered state only, so a slot freed on an edge is
    // neither advertised nor reallocated until the following cycle.
    always_comb begin
        free_vec     = '0;
        alloc_sel    = '0;
        alloc_tag    = TAG_NONE;
        dispatch_sel = '0;
        exec_tag     = TAG_NONE;
        done_dest    = '0;
        adder_busy   = 1'b0;
        done_any     = 1'b0;
        disp_op      = '0;
        disp_a       = '0;
        disp_b       = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            free_vec[i] = (rs_q[i].state == RS_FREE);
            if ((rs_q[i].state == RS_EXEC) || (rs_q[i].state == RS_DONE)) begin
                adder_busy = 1'b1;
                exec_tag   = entry_tag(i);
            end
            if (rs_q[i].state == RS_DONE) begin
                done_any  = 1'b1;
                done_dest = rs_q[i].dest;
            end
        end
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (rs_q[i].state == RS_FREE) begin
                alloc_sel    = '0;
                alloc_sel[i] = 1'b1;
                alloc_tag    = entry_tag(i);
            end
            if (!adder_busy && (rs_q[i].state == RS_READY)) begin
                dispatch_sel    = '0;
                dispatch_sel[i] = 1'b1;
                disp_op         = rs_q[i].op;
                disp_a          = rs_q[i].a.value;
                disp_b          = rs_q[i].b.value;
            end
        end
    end

    assign dispatch_valid = |dispatch_sel;
    assign issue_ok       = issue && is_adder_op(operation) && (|alloc_sel);
    assign issue_a        = snoop('{tag: A_tag, value: A_value}, cdb_valid, cdb_tag, cdb_value);
    assign issue_b        = snoop('{tag: B_tag, value: B_value}, cdb_valid, cdb_tag, cdb_value);

    // Next-state: each entry advances independently; only one can be in the adder.
    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            rs_d[i] = rs_q[i];
            case (rs_q[i].state)
                RS_FREE: begin
                    if (issue_ok && alloc_sel[i]) begin
                        rs_d[i].op   = operation;
                        rs_d[i].dest = Dest_address;
                        rs_d[i].a    = issue_a;
                        rs_d[i].b    = issue_b;
                        rs_d[i].state = ((issue_a.tag == TAG_NONE) && (issue_b.tag == TAG_NONE))
                                        ? RS_READY : RS_WAIT;
                    end
                end
                RS_WAIT: begin
                    rs_d[i].a = snoop(rs_q[i].a, cdb_valid, cdb_tag, cdb_value);
                    rs_d[i].b = snoop(rs_q[i].b, cdb_valid, cdb_tag, cdb_value);
                    if ((rs_d[i].a.tag == TAG_NONE) && (rs_d[i].b.tag == TAG_NONE)) begin
                        rs_d[i].state = RS_READY;
                    end
                end
                RS_READY: begin
                    if (dispatch_sel[i]) begin
                        rs_d[i].state = RS_EXEC;
                    end
                end
                RS_EXEC: begin
                    if (pipe_done) begin
                        rs_d[i].state = RS_DONE;
                    end
                end
                RS_DONE: begin
                    if (cdb_grant) begin
                        rs_d[i].state = RS_FREE;
                    end
                end
                default: rs_d[i].state = RS_FREE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        adder_available    = |free_vec;
        adder_RS_available = alloc_tag;
        RS_executing_adder = exec_tag;
        adder_rts          = done_any;
        result_dest        = done_dest;
    end

endmodule

// File: tb/tb_adder_reservation_stations.sv
// Directed self-checking bench for adder_reservation_stations: a vector table
// of single ADD/SUB transactions plus hand-written multi-cycle corner sequences.
module tb_adder_reservation_stations;

    localparam logic [5:0] ADD = 6'h20;
    localparam logic [5:0] SUB = 6'h22;

    logic        clock;
    logic        reset_n;
    logic        issue;
    logic [5:0]  operation;
    logic [4:0]  Dest_address;
    logic [5:0]  A_tag;
    logic [5:0]  B_tag;
    logic [31:0] A_value;
    logic [31:0] B_value;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_grant;
    logic        adder_available;
    logic [5:0]  adder_RS_available;
    logic [5:0]  RS_issued;
    logic        issue_error;
    logic [5:0]  RS_executing_adder;
    logic        adder_rts;
    logic [5:0]  RS_finished;
    logic [31:0] result_value;
    logic [4:0]  result_dest;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs [5];

    adder_reservation_stations dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .issue              (issue),
        .operation          (operation),
        .Dest_address       (Dest_address),
        .A_tag              (A_tag),
        .B_tag              (B_tag),
        .A_value            (A_value),
        .B_value            (B_value),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .cdb_value          (cdb_value),
        .cdb_grant          (cdb_grant),
        .adder_available    (adder_available),
        .adder_RS_available (adder_RS_available),
        .RS_issued          (RS_issued),
        .issue_error        (issue_error),
        .RS_executing_adder (RS_executing_adder),
        .adder_rts          (adder_rts),
        .RS_finished        (RS_finished),
        .result_value       (result_value),
        .result_dest        (result_dest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] at, input logic [31:0] av,
                                  input logic [5:0] bt, input logic [31:0] bv, input logic [4:0] dest);
        issue        = 1'b1;
        operation    = op;
        A_tag        = at;
        A_value      = av;
        B_tag        = bt;
        B_value      = bv;
        Dest_address = dest;
    endtask

    task automatic clear_inputs();
        issue        = 1'b0;
        operation    = '0;
        A_tag        = '0;
        A_value      = '0;
        B_tag        = '0;
        B_value      = '0;
        Dest_address = '0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        cdb_value    = '0;
        cdb_grant    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{op: ADD, a: 32'd5,          b: 32'd7,          dest: 5'd3,  exp_result: 32'd12};
        vecs[1] = '{op: SUB, a: 32'd10,         b: 32'd3,          dest: 5'd7,  exp_result: 32'd7};
        vecs[2] = '{op: ADD, a: 32'hFFFF_FFFF,  b: 32'd2,          dest: 5'd31, exp_result: 32'd1};
        vecs[3] = '{op: SUB, a: 32'd0,          b: 32'd1,          dest: 5'd0,  exp_result: 32'hFFFF_FFFF};
        vecs[4] = '{op: ADD, a: 32'h1234_5678,  b: 32'h1111_1111,  dest: 5'd15, exp_result: 32'h2345_6789};

        clear_inputs();
        reset_n = 1'b0;
        #12;
        check_output("rst_available", adder_available, 1);
        check_output("rst_rs_avail", adder_RS_available, 1);
        check_output("rst_issued", RS_issued, 0);
        check_output("rst_issue_error", issue_error, 0);
        check_output("rst_executing", RS_executing_adder, 0);
        check_output("rst_rts", adder_rts, 0);
        check_output("rst_finished", RS_finished, 0);
        check_output("rst_result", result_value, 0);
        check_output("rst_dest", result_dest, 0);
        reset_n = 1'b1;

        $display("[TB] vector table: single ready-at-issue transactions");
        for (int v = 0; v < 5; v++) begin
            apply_stimulus(vecs[v].op, 6'd0, vecs[v].a, 6'd0, vecs[v].b, vecs[v].dest);
            tick();
            issue = 1'b0;
            check_output("vec_issued", RS_issued, 1);
            check_output("vec_rs_avail", adder_RS_available, 2);
            tick();
            check_output("vec_executing", RS_executing_adder, 1);
            check_output("vec_issued_pulse", RS_issued, 0);
            cdb_grant = 1'b1;
            tick();
            cdb_grant = 1'b0;
            check_output("vec_rts_early", adder_rts, 0);
            check_output("vec_no_finish", RS_finished, 0);
            tick();
            check_output("vec_rts", adder_rts, 1);
            check_output("vec_result", result_value, vecs[v].exp_result);
            check_output("vec_dest", result_dest, vecs[v].dest);
            cdb_grant = 1'b1;
            tick();
            cdb_grant = 1'b0;
            check_output("vec_finished", RS_finished, 1);
            check_output("vec_rts_clear", adder_rts, 0);
            check_output("vec_exec_clear", RS_executing_adder, 0);
            check_output("vec_rs_freed", adder_RS_available, 1);
            tick();
            check_output("vec_finished_pulse", RS_finished, 0);
        end

        $display("[TB] full bank and illegal opcode");
        do_reset();
        for (int n = 1; n <= 3; n++) begin
            apply_stimulus(ADD, 6'd9, 32'd0, 6'd0, 32'd1, 5'(n));
            tick();
            check_output("full_issued", RS_issued, 32'(n));
        end
        check_output("full_available", adder_available, 0);
        check_output("full_rs_avail", adder_RS_available, 0);
        tick();
        issue = 1'b0;
        check_output("full_error", issue_error, 1);
        check_output("full_no_alloc", RS_issued, 0);
        check_output("full_exec_idle", RS_executing_adder, 0);
        do_reset();
        apply_stimulus(6'h21, 6'd0, 32'd1, 6'd0, 32'd1, 5'd1);
        tick();
        issue = 1'b0;
        check_output("illegal_error", issue_error, 1);
        check_output("illegal_no_alloc", RS_issued, 0);
        check_output("illegal_rs_avail", adder_RS_available, 1);
        tick();
        check_output("illegal_error_pulse", issue_error, 0);

        $display("[TB] CDB snoop with subtract wrap");
        do_reset();
        apply_stimulus(SUB, 6'd9, 32'd0, 6'd0, 32'd1, 5'd4);
        tick();
        issue = 1'b0;
        check_output("snoop_issued", RS_issued, 1);
        tick();
        check_output("snoop_waiting", RS_executing_adder, 0);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_value = 32'd0;
        tick();
        cdb_valid = 1'b0;
        check_output("snoop_not_yet", RS_executing_adder, 0);
        tick();
        check_output("snoop_dispatch", RS_executing_adder, 1);
        tick();
        tick();
        check_output("snoop_rts", adder_rts, 1);
        check_output("snoop_result", result_value, 32'hFFFF_FFFF);
        check_output("snoop_dest", result_dest, 4);

        $display("[TB] issue-time CDB bypass");
        do_reset();
        apply_stimulus(ADD, 6'd4, 32'd99, 6'd0, 32'd5, 5'd9);
        cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_value = 32'd10;
        tick();
        issue = 1'b0; cdb_valid = 1'b0;
        tick();
        check_output("bypass_dispatch", RS_executing_adder, 1);
        tick();
        tick();
        check_output("bypass_rts", adder_rts, 1);
        check_output("bypass_result", result_value, 15);

        $display("[TB] grant withheld with a second ready entry");
        do_reset();
        apply_stimulus(ADD, 6'd0, 32'd1, 6'd0, 32'd1, 5'd1);
        tick();
        apply_stimulus(ADD, 6'd0, 32'd2, 6'd0, 32'd2, 5'd2);
        tick();
        issue = 1'b0;
        check_output("hold_issued2", RS_issued, 2);
        check_output("hold_exec1", RS_executing_adder, 1);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            check_output("hold_rts", adder_rts, 1);
            check_output("hold_exec", RS_executing_adder, 1);
            if (c < 4) tick();
        end
        check_output("hold_result", result_value, 2);
        cdb_grant = 1'b1;
        tick();
        check_output("hold_finished1", RS_finished, 1);
        check_output("hold_exec_idle", RS_executing_adder, 0);
        tick();
        check_output("hold_exec2", RS_executing_adder, 2);
        check_output("hold_stray_grant", adder_rts, 0);
        tick();
        cdb_grant = 1'b0;
        check_output("hold_grant_ignored", RS_finished, 0);
        check_output("hold_exec2_kept", RS_executing_adder, 2);
        tick();
        check_output("hold_rts2", adder_rts, 1);
        check_output("hold_result2", result_value, 4);
        check_output("hold_dest2", result_dest, 2);
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
        check_output("hold_finished2", RS_finished, 2);

        $display("[TB] completion and issue on the same edge");
        do_reset();
        apply_stimulus(ADD, 6'd0, 32'd3, 6'd0, 32'd4, 5'd1);
        tick();
        apply_stimulus(ADD, 6'd9, 32'd0, 6'd0, 32'd0, 5'd2);
        tick();
        tick();
        issue = 1'b0;
        tick();
        check_output("same_rts", adder_rts, 1);
        check_output("same_full", adder_available, 0);
        apply_stimulus(ADD, 6'd0, 32'd1, 6'd0, 32'd1, 5'd5);
        cdb_grant = 1'b1;
        tick();
        issue = 1'b0; cdb_grant = 1'b0;
        check_output("same_finished", RS_finished, 1);
        check_output("same_error", issue_error, 1);
        check_output("same_no_alloc", RS_issued, 0);
        check_output("same_rs_avail", adder_RS_available, 1);

        $display("[TB] reset during execution");
        do_reset();
        apply_stimulus(ADD, 6'd0, 32'd8, 6'd0, 32'd8, 5'd6);
        tick();
        issue = 1'b0;
        tick();
        check_output("mid_exec", RS_executing_adder, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("mid_rst_exec", RS_executing_adder, 0);
        check_output("mid_rst_available", adder_available, 1);
        check_output("mid_rst_rs_avail", adder_RS_available, 1);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        check_output("mid_rst_no_rts", adder_rts, 0);
        check_output("mid_rst_result", result_value, 0);
        check_output("mid_rst_after", adder_RS_available, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
